// File: rtl/data_axi_bridge.sv
// data_axi_bridge: turns the core's hold-until-done data port into
// single-beat AXI4 master reads and writes, one transaction at a time.
module data_axi_bridge #(
   parameter logic [3:0] RD_ID = 4'd0,
   parameter logic [3:0] WR_ID = 4'd1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        data_axi_ren,
   input  logic        data_axi_wen,
   input  logic [3:0]  data_axi_wsel,
   input  logic [31:0] data_axi_addr,
   input  logic [31:0] data_axi_wdata,
   input  logic        axi_flush,
   output logic [31:0] data_axi_rdata,
   output logic        data_axi_rvalid,
   output logic        data_axi_bvalid,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR_REQ,
      S_WR_RESP,
      S_DONE
   } state_t;

   state_t      r_state;
   logic        r_discard;
   logic        r_aw_done;
   logic        r_w_done;
   logic [31:0] r_rdata;
   logic        r_rd_pulse;
   logic        r_wr_pulse;
   logic [31:0] r_araddr;
   logic        r_arvalid;
   logic        r_rready;
   logic [31:0] r_awaddr;
   logic [2:0]  r_awsize;
   logic        r_awvalid;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_wvalid;
   logic        r_bready;

   logic        w_busy;
   logic        w_discard_nxt;
   logic        w_aw_fin;
   logic        w_w_fin;
   logic [2:0]  w_pop;
   logic [2:0]  w_awsize;
   logic        w_unused;

   // Response IDs, error codes and rlast carry no information for a
   // single outstanding single-beat transaction.
   assign w_unused = ^{rid, rresp, rlast, bid, bresp};

   assign w_busy = (r_state == S_RD_ADDR) || (r_state == S_RD_DATA) ||
                   (r_state == S_WR_REQ)  || (r_state == S_WR_RESP);
   assign w_discard_nxt = r_discard | (w_busy & axi_flush);

   assign w_aw_fin = r_aw_done | (r_awvalid & awready);
   assign w_w_fin  = r_w_done  | (r_wvalid & wready);

   // Transfer size follows how many byte lanes the write touches.
   always_comb begin
      w_pop = {2'b00, data_axi_wsel[0]} + {2'b00, data_axi_wsel[1]} +
              {2'b00, data_axi_wsel[2]} + {2'b00, data_axi_wsel[3]};
      case (w_pop)
         3'd1:    w_awsize = 3'd0;
         3'd2:    w_awsize = 3'd1;
         default: w_awsize = 3'd2;
      endcase
   end

   // Transaction sequencer with all bus-facing outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_discard  <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         r_rdata    <= 32'd0;
         r_rd_pulse <= 1'b0;
         r_wr_pulse <= 1'b0;
         r_araddr   <= 32'd0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_awaddr   <= 32'd0;
         r_awsize   <= 3'd0;
         r_awvalid  <= 1'b0;
         r_wdata    <= 32'd0;
         r_wstrb    <= 4'd0;
         r_wvalid   <= 1'b0;
         r_bready   <= 1'b0;
      end else begin
         r_rd_pulse <= 1'b0;
         r_wr_pulse <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_discard <= 1'b0;
               if (!axi_flush) begin
                  if (data_axi_wen) begin
                     r_awaddr  <= data_axi_addr;
                     r_wdata   <= data_axi_wdata;
                     r_wstrb   <= data_axi_wsel;
                     r_awsize  <= w_awsize;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                     r_state   <= S_WR_REQ;
                  end else if (data_axi_ren) begin
                     r_araddr  <= {data_axi_addr[31:2], 2'b00};
                     r_arvalid <= 1'b1;
                     r_state   <= S_RD_ADDR;
                  end
               end
            end
            S_RD_ADDR: begin
               r_discard <= w_discard_nxt;
               if (arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               r_discard <= w_discard_nxt;
               if (rvalid) begin
                  r_rready <= 1'b0;
                  if (!w_discard_nxt) begin
                     r_rdata    <= rdata;
                     r_rd_pulse <= 1'b1;
                  end
                  r_state <= S_DONE;
               end
            end
            S_WR_REQ: begin
               r_discard <= w_discard_nxt;
               if (r_awvalid && awready) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (r_wvalid && wready) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_fin && w_w_fin) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_bready  <= 1'b1;
                  r_state   <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               r_discard <= w_discard_nxt;
               if (bvalid) begin
                  r_bready <= 1'b0;
                  if (!w_discard_nxt) begin
                     r_wr_pulse <= 1'b1;
                  end
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_discard <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign data_axi_rdata  = r_rdata;
   assign data_axi_rvalid = r_rd_pulse;
   assign data_axi_bvalid = r_wr_pulse;

   assign arid    = RD_ID;
   assign araddr  = r_araddr;
   assign arlen   = 8'd0;
   assign arsize  = 3'd2;
   assign arburst = 2'b01;
   assign arvalid = r_arvalid;
   assign rready  = r_rready;

   assign awid    = WR_ID;
   assign awaddr  = r_awaddr;
   assign awlen   = 8'd0;
   assign awsize  = r_awsize;
   assign awburst = 2'b01;
   assign awvalid = r_awvalid;
   assign wdata   = r_wdata;
   assign wstrb   = r_wstrb;
   assign wlast   = 1'b1;
   assign wvalid  = r_wvalid;
   assign bready  = r_bready;

endmodule
